// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package pipe_addsub_pkg;

    // Operation codes carried on in_ctl
    typedef enum logic [3:0] {
        CTL_ADDU = 4'b0000,
        CTL_ADD  = 4'b0001,
        CTL_SUBU = 4'b0010,
        CTL_SUB  = 4'b0011
    } alu_ctl_e;

    // Status flags produced alongside every result
    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
        logic err;
    } flags_t;

    // Only the four listed codes are executed; anything else is flagged as an error
    function automatic logic ctl_legal(input logic [3:0] ctl);
        logic ok;
        ok = 1'b0;
        case (ctl)
            CTL_ADDU, CTL_ADD, CTL_SUBU, CTL_SUB: ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Bit 1 of a legal code selects subtract, bit 0 selects signed (overflow-reporting)
    function automatic logic ctl_is_sub(input logic [3:0] ctl);
        return ctl[1];
    endfunction

    function automatic logic ctl_is_signed(input logic [3:0] ctl);
        return ctl[0];
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result bundle between issue logic and the add/subtract unit.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand side and the result side.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       in_ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;
    logic             out_err;

    // Requester: supplies operands and consumes results
    modport master (
        output in_valid, in_a, in_b, in_cin, in_ctl, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_neg, out_err
    );

    // The arithmetic unit itself
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_ctl, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_neg, out_err
    );
endinterface

// File: rtl/pipe_addsub_slice.sv
// Combinational W-bit carry-lookahead adder slice (a + b + cin -> sum, cout).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline decides when its result is captured.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry at each bit from generate/propagate terms, seeded by the slice carry-in
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: carry chain cut into STAGES slices, one slice per register stage.
// Latency: exactly STAGES cycles from accept to out_valid while out_ready stays high; 1 bundle/cycle.
// Backpressure: whole pipe freezes when out_valid & ~out_ready; in_ready mirrors the advance enable.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    // Intermediate stage registers exist for stages 0..STAGES-2; the last stage lands in res_q/flg_q
    localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;

    logic              adv;
    logic              in_fire;
    logic              legal;

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q [NI];
    logic [WIDTH-1:0]  b_q [NI];
    logic [WIDTH-1:0]  r_q [NI];
    logic [NI-1:0]     c_q;
    logic [NI-1:0]     sgn_q;
    logic [NI-1:0]     err_q;

    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  r_src [STAGES];
    logic [WIDTH-1:0]  r_nxt [STAGES];
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] sgn_src;
    logic [STAGES-1:0] err_src;
    logic [STAGES-1:0] cout_all;
    logic [WIDTH-1:0]  sum_all;

    logic [WIDTH-1:0]  res_d;
    logic [WIDTH-1:0]  res_q;
    flags_t            flg_d;
    flags_t            flg_q;

    assign legal   = ctl_legal(bus.in_ctl);
    assign adv     = ~v_q[STAGES-1] | bus.out_ready;
    assign in_fire = bus.in_valid & adv;

    // Stage inputs: stage 0 takes the (pre-inverted for subtract) operands, later stages the previous register
    always_comb begin
        v_src   = '0;
        c_src   = '0;
        sgn_src = '0;
        err_src = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_src[k] = '0;
            b_src[k] = '0;
            r_src[k] = '0;
            r_nxt[k] = '0;
        end
        v_src[0]   = in_fire;
        a_src[0]   = bus.in_a;
        b_src[0]   = ctl_is_sub(bus.in_ctl) ? ~bus.in_b : bus.in_b;
        c_src[0]   = ctl_is_sub(bus.in_ctl) | bus.in_cin;
        sgn_src[0] = ctl_is_signed(bus.in_ctl);
        err_src[0] = ~legal;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k]   = v_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            r_src[k]   = r_q[k-1];
            c_src[k]   = c_q[k-1];
            sgn_src[k] = sgn_q[k-1];
            err_src[k] = err_q[k-1];
        end
        // Each stage drops its slice sum into the travelling partial result
        for (int k = 0; k < STAGES; k++) begin
            r_nxt[k]             = r_src[k];
            r_nxt[k][k*SW +: SW] = sum_all[k*SW +: SW];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(
            .W (SW)
        ) u_slice (
            .a    (a_src[k][k*SW +: SW]),
            .b    (b_src[k][k*SW +: SW]),
            .cin  (c_src[k]),
            .sum  (sum_all[k*SW +: SW]),
            .cout (cout_all[k])
        );
    end

    // Final-stage flags from the operand signs (B already inverted for subtract) and the completed sum
    always_comb begin
        res_d     = r_nxt[STAGES-1];
        flg_d     = '0;
        flg_d.carry = cout_all[STAGES-1];
        flg_d.ovf   = sgn_src[STAGES-1]
                    & (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
                    & (res_d[WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
        flg_d.zero  = (res_d == '0);
        flg_d.neg   = res_d[WIDTH-1];
        if (err_src[STAGES-1]) begin
            res_d     = '0;
            flg_d     = '0;
            flg_d.err = 1'b1;
        end
    end

    // All stage registers advance together; nothing moves while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            sgn_q <= '0;
            err_q <= '0;
            res_q <= '0;
            flg_q <= '0;
            for (int k = 0; k < NI; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (adv) begin
            v_q   <= v_src;
            res_q <= res_d;
            flg_q <= flg_d;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k]   <= a_src[k];
                b_q[k]   <= b_src[k];
                r_q[k]   <= r_nxt[k];
                c_q[k]   <= cout_all[k];
                sgn_q[k] <= sgn_src[k];
                err_q[k] <= err_src[k];
            end
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = v_q[STAGES-1];
    assign bus.out_result = res_q;
    assign bus.out_carry  = flg_q.carry;
    assign bus.out_ovf    = flg_q.ovf;
    assign bus.out_zero   = flg_q.zero;
    assign bus.out_neg    = flg_q.neg;
    assign bus.out_err    = flg_q.err;
endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub at STAGES=4, with STAGES=1 and STAGES=32 copies fed the same accepted bundles.
// Latency: checked per bundle against the configured depth while out_ready is held high.
// Backpressure: random out_ready on the 4-stage unit; stalled outputs must stay stable.
module tb_pipe_addsub;

    typedef struct {
        logic [31:0] res;
        logic        c, o, z, n, e;
        int          lat;
        int          acc;
        int          tag;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        cin;
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        c, o, z, n, e;
    } vec_t;

    // Hand-computed directed vectors: a, b, cin, ctl -> result, carry, ovf, zero, neg, err
    vec_t dv [9] = '{
        '{32'h7FFFFFFF, 32'h00000001, 1'b0, 4'b0001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
        '{32'h00000005, 32'h00000005, 1'b0, 4'b0011, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
        '{32'h00000000, 32'h00000001, 1'b0, 4'b0010, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
        '{32'h12345678, 32'h00000001, 1'b0, 4'b0111, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
        '{32'h80000000, 32'h00000001, 1'b0, 4'b0011, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{32'h0000000A, 32'h00000003, 1'b1, 4'b0011, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
        '{32'h0000FFFF, 32'h00000001, 1'b0, 4'b0000, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b0001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}
    };

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tagn = 0;
    bit   bp_mode = 0;
    bit   held = 0;
    logic [36:0] snap;
    exp_t q4[$];
    exp_t q1[$];
    exp_t q32[$];
    exp_t e4, e1, e32;

    pipe_addsub_if #(.WIDTH(32)) b4();
    pipe_addsub_if #(.WIDTH(32)) b1();
    pipe_addsub_if #(.WIDTH(32)) b32();

    pipe_addsub #(.WIDTH(32), .STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    pipe_addsub #(.WIDTH(32), .STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    pipe_addsub #(.WIDTH(32), .STAGES(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    // The shallow and deep copies see exactly the bundles the 4-stage unit accepts
    assign b1.in_valid   = b4.in_valid & b4.in_ready;
    assign b1.in_a       = b4.in_a;
    assign b1.in_b       = b4.in_b;
    assign b1.in_cin     = b4.in_cin;
    assign b1.in_ctl     = b4.in_ctl;
    assign b1.out_ready  = 1'b1;
    assign b32.in_valid  = b4.in_valid & b4.in_ready;
    assign b32.in_a      = b4.in_a;
    assign b32.in_b      = b4.in_b;
    assign b32.in_cin    = b4.in_cin;
    assign b32.in_ctl    = b4.in_ctl;
    assign b32.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) b4.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic compare(input string nm, input exp_t e, input logic [31:0] r,
                           input logic c, input logic o, input logic z, input logic n, input logic er);
        checks++;
        if ({r, c, o, z, n, er} !== {e.res, e.c, e.o, e.z, e.n, e.e}) begin
            errors++;
            $display("FAIL %s tag %0d: got res=%h c=%b v=%b z=%b n=%b err=%b want res=%h c=%b v=%b z=%b n=%b err=%b",
                     nm, e.tag, r, c, o, z, n, er, e.res, e.c, e.o, e.z, e.n, e.e);
        end
        if (e.lat >= 0) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
                errors++;
                $display("FAIL %s_latency tag %0d: got %0d want %0d", nm, e.tag, cyc - e.acc, e.lat);
            end
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: output with empty scoreboard at cycle %0d", nm, cyc);
    endtask

    // Independent reference: wide unsigned sum for carry, signed range test for overflow
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [3:0] ctl);
        exp_t   e;
        longint sa, sb, sr;
        logic [32:0] u;
        e.res = '0; e.c = 0; e.o = 0; e.z = 0; e.n = 0; e.e = 0;
        e.lat = -1; e.acc = 0; e.tag = 0;
        if (ctl[3:2] != 2'b00) begin
            e.e = 1'b1;
            return e;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (ctl[1]) begin
            u   = {1'b0, a} - {1'b0, b};
            e.c = ~u[32];
            sr  = sa - sb;
        end else begin
            u   = {1'b0, a} + {1'b0, b} + 33'(cin);
            e.c = u[32];
            sr  = sa + sb + longint'(cin);
        end
        e.res = u[31:0];
        e.z   = (u[31:0] == 32'h0);
        e.n   = u[31];
        e.o   = ctl[0] & ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [3:0] ctl, input exp_t e, input bit chk_lat);
        int t;
        t = 0;
        @(negedge clk);
        b4.in_valid = 1'b1;
        b4.in_a     = a;
        b4.in_b     = b;
        b4.in_cin   = cin;
        b4.in_ctl   = ctl;
        #2;
        while (!b4.in_ready && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        checks++;
        if (!b4.in_ready) begin
            errors++;
            $display("FAIL accept_timeout tag %0d: in_ready stayed %b, want 1", tagn, b4.in_ready);
        end else begin
            e.acc = cyc;
            e.tag = tagn;
            e.lat = chk_lat ? 4 : -1;
            q4.push_back(e);
            e.lat = 1;
            q1.push_back(e);
            e.lat = 32;
            q32.push_back(e);
        end
        tagn++;
    endtask

    task automatic idle();
        @(negedge clk);
        b4.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((q4.size() + q1.size() + q32.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 64'(q4.size() + q1.size() + q32.size()), 64'd0);
    endtask

    // 4-stage monitor: pops on each handshake and checks stalled outputs do not move
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (b4.out_valid && !b4.out_ready) begin
                if (held) chk("stall_stable", 64'({b4.out_result, b4.out_carry, b4.out_ovf, b4.out_zero, b4.out_neg, b4.out_err}), 64'(snap));
                held = 1;
                snap = {b4.out_result, b4.out_carry, b4.out_ovf, b4.out_zero, b4.out_neg, b4.out_err};
            end else begin
                held = 0;
            end
            if (b4.out_valid && b4.out_ready) begin
                if (q4.size() == 0) unexpected("s4");
                else begin
                    e4 = q4.pop_front();
                    compare("s4", e4, b4.out_result, b4.out_carry, b4.out_ovf, b4.out_zero, b4.out_neg, b4.out_err);
                end
            end
        end else begin
            held = 0;
        end
    end

    // Single-stage monitor
    always begin
        @(negedge clk);
        #2;
        if (rst_n && b1.out_valid) begin
            if (q1.size() == 0) unexpected("s1");
            else begin
                e1 = q1.pop_front();
                compare("s1", e1, b1.out_result, b1.out_carry, b1.out_ovf, b1.out_zero, b1.out_neg, b1.out_err);
            end
        end
    end

    // 32-stage monitor
    always begin
        @(negedge clk);
        #2;
        if (rst_n && b32.out_valid) begin
            if (q32.size() == 0) unexpected("s32");
            else begin
                e32 = q32.pop_front();
                compare("s32", e32, b32.out_result, b32.out_carry, b32.out_ovf, b32.out_zero, b32.out_neg, b32.out_err);
            end
        end
    end

    initial begin
        exp_t e;
        int   stale;
        logic [31:0] ra, rb;
        logic        rc;
        logic [3:0]  rctl;

        rst_n        = 1'b1;
        b4.in_valid  = 1'b0;
        b4.in_a      = '0;
        b4.in_b      = '0;
        b4.in_cin    = 1'b0;
        b4.in_ctl    = '0;
        b4.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid4", 64'(b4.out_valid), 64'd0);
        chk("reset_out_valid1", 64'(b1.out_valid), 64'd0);
        chk("reset_out_valid32", 64'(b32.out_valid), 64'd0);
        chk("reset_in_ready", 64'(b4.in_ready), 64'd1);
        chk("reset_result", 64'({b4.out_result, b4.out_carry, b4.out_ovf, b4.out_zero, b4.out_neg, b4.out_err}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors back to back with out_ready held high
        for (int i = 0; i < 9; i++) begin
            e.res = dv[i].res; e.c = dv[i].c; e.o = dv[i].o; e.z = dv[i].z; e.n = dv[i].n; e.e = dv[i].e;
            e.lat = -1; e.acc = 0; e.tag = 0;
            send(dv[i].a, dv[i].b, dv[i].cin, dv[i].ctl, e, 1'b1);
        end
        idle();
        drain("drain_directed");

        // Reset with bundles still in flight: nothing may emerge afterwards
        for (int i = 0; i < 2; i++) begin
            e = model(32'h00001000 + 32'(i), 32'h00000022, 1'b0, 4'b0000);
            send(32'h00001000 + 32'(i), 32'h00000022, 1'b0, 4'b0000, e, 1'b1);
        end
        @(negedge clk);
        b4.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid4", 64'(b4.out_valid), 64'd0);
        chk("midreset_out_valid32", 64'(b32.out_valid), 64'd0);
        q4.delete();
        q1.delete();
        q32.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            #2;
            if (b4.out_valid || b1.out_valid || b32.out_valid) stale++;
        end
        chk("no_stale_after_reset", 64'(stale), 64'd0);

        // Random bundles under random backpressure
        bp_mode = 1;
        for (int i = 0; i < 10; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            rctl = 4'($urandom_range(0, 3));
            e    = model(ra, rb, rc, rctl);
            send(ra, rb, rc, rctl, e, 1'b0);
        end
        idle();
        repeat (20) @(negedge clk);
        bp_mode = 0;
        drain("drain_backpressure");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
